interval_timer: RTL and testbench

//  Programmable interval timer that paces the traffic-light controller. It holds the

---
 rtl/interval_timer_if.sv | 25 ++
 rtl/interval_timer.sv | 82 ++++++++
 tb/tb_interval_timer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_if.sv
// Control/status bundle between the traffic-light controller (master) and
// the interval timer (slave).
interface interval_timer_if #(
  parameter int VAL_W = 4
);
  logic             start_timer;
  logic [1:0]       interval_address;
  logic             prg_load;
  logic [1:0]       prg_select;
  logic [VAL_W-1:0] prg_value;
  logic             expired;
  logic             busy;
  logic [VAL_W-1:0] remaining;
  logic             second_tick;

  modport master (
    output start_timer, interval_address, prg_load, prg_select, prg_value,
    input  expired, busy, remaining, second_tick
  );

  modport slave (
    input  start_timer, interval_address, prg_load, prg_select, prg_value,
    output expired, busy, remaining, second_tick
  );
endinterface

// File: rtl/interval_timer.sv
// Programmable whole-second interval timer with a 3-entry interval table;
// a prescaler turns CLK_DIV clk cycles into one second.
module interval_timer #(
  parameter int CLK_DIV      = 100000000,
  parameter int VAL_W        = 4,
  parameter int BASE_DEFAULT = 6,
  parameter int EXT_DEFAULT  = 3,
  parameter int YEL_DEFAULT  = 2
) (
  input  logic            clk,
  input  logic            sys_reset,
  interval_timer_if.slave tif
);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PS_MAX = PW'(CLK_DIV - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t           state;
  logic [PW-1:0]    prescaler;
  logic [VAL_W-1:0] tbl_base, tbl_ext, tbl_yel;
  logic [VAL_W-1:0] load_val;

  // Zero-length entries and the fixed address 3 both run for one second.
  always_comb begin
    load_val = VAL_W'(1);
    case (tif.interval_address)
      2'd0:    if (tbl_base != '0) load_val = tbl_base;
      2'd1:    if (tbl_ext  != '0) load_val = tbl_ext;
      2'd2:    if (tbl_yel  != '0) load_val = tbl_yel;
      default: load_val = VAL_W'(1);
    endcase
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state           <= IDLE;
      prescaler       <= '0;
      tbl_base        <= VAL_W'(BASE_DEFAULT);
      tbl_ext         <= VAL_W'(EXT_DEFAULT);
      tbl_yel         <= VAL_W'(YEL_DEFAULT);
      tif.expired     <= 1'b0;
      tif.busy        <= 1'b0;
      tif.remaining   <= '0;
      tif.second_tick <= 1'b0;
    end else begin
      tif.expired     <= 1'b0;
      tif.second_tick <= 1'b0;
      if (tif.prg_load) begin
        // Programming always aborts the running interval silently.
        case (tif.prg_select)
          2'd0:    tbl_base <= tif.prg_value;
          2'd1:    tbl_ext  <= tif.prg_value;
          2'd2:    tbl_yel  <= tif.prg_value;
          default: ;
        endcase
        state         <= IDLE;
        prescaler     <= '0;
        tif.busy      <= 1'b0;
        tif.remaining <= '0;
      end else if (tif.start_timer) begin
        state         <= COUNT;
        prescaler     <= '0;
        tif.busy      <= 1'b1;
        tif.remaining <= load_val;
      end else if (state == COUNT) begin
        if (prescaler == PS_MAX) begin
          prescaler       <= '0;
          tif.second_tick <= 1'b1;
          tif.remaining   <= tif.remaining - VAL_W'(1);
          if (tif.remaining == VAL_W'(1)) begin
            tif.expired <= 1'b1;
            tif.busy    <= 1'b0;
            state       <= IDLE;
          end
        end else begin
          prescaler <= prescaler + PW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_interval_timer.sv
// Randomized and directed bench for interval_timer; expected behaviour comes
// from a deadline-based model (expiry cycle = start cycle + N*CLK_DIV).
module tb_interval_timer;
  localparam int D = 4;

  logic clk = 1'b0;
  logic sys_reset = 1'b0;
  always #5 clk = ~clk;

  interval_timer_if #(.VAL_W(4)) tif();

  interval_timer #(.CLK_DIV(D), .VAL_W(4)) dut (
    .clk(clk), .sys_reset(sys_reset), .tif(tif.slave)
  );

  int tests = 0;
  int fails = 0;

  // reference model
  int       cyc = 0;
  bit       active = 1'b0;
  int       sstart = 0;
  int       deadline = 0;
  int       tbl [3];

  function void model_reset();
    active = 1'b0;
    tbl[0] = 6; tbl[1] = 3; tbl[2] = 2;
  endfunction

  function int eff(input int a);
    if (a == 3) return 1;
    return (tbl[a] == 0) ? 1 : tbl[a];
  endfunction

  function logic [6:0] mvec();
    bit b, e, t;
    int r;
    b = active && cyc < deadline;
    e = active && cyc == deadline;
    r = b ? (deadline - cyc + D - 1) / D : 0;
    t = active && cyc > sstart && cyc <= deadline && ((cyc - sstart) % D) == 0;
    return {e, b, 4'(r), t};
  endfunction

  function logic [6:0] obs();
    return {tif.expired, tif.busy, tif.remaining, tif.second_tick};
  endfunction

  // Drive one cycle of inputs (called at negedge), advance model at posedge.
  task step(input bit st, input int a, input bit pl, input int ps, input int pv);
    tif.start_timer = st; tif.interval_address = 2'(a);
    tif.prg_load = pl; tif.prg_select = 2'(ps); tif.prg_value = 4'(pv);
    @(posedge clk);
    cyc++;
    if (pl) begin
      if (ps != 3) tbl[ps] = pv;
      active = 1'b0;
    end else if (st) begin
      active = 1'b1; sstart = cyc; deadline = cyc + eff(a) * D;
    end
    @(negedge clk);
    tif.start_timer = 1'b0; tif.prg_load = 1'b0;
  endtask

  task idle();
    step(0, 0, 0, 0, 0);
  endtask

  task test_reset();
    tif.start_timer = 0; tif.interval_address = 0; tif.prg_load = 0;
    tif.prg_select = 0; tif.prg_value = 0;
    model_reset();
    sys_reset = 1'b0;
    repeat (3) @(negedge clk);
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL reset_outputs got %b want %b", obs(), 7'd0);
    end
    tests++;
    sys_reset = 1'b1;
    idle();
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL reset_idle got %b want %b", obs(), 7'd0);
    end
    tests++;
  endtask

  task test_base();
    int s0, first;
    first = -1;
    step(1, 0, 0, 0, 0); s0 = cyc;
    if (obs() !== {1'b0, 1'b1, 4'd6, 1'b0}) begin
      fails++; $display("FAIL base_load got %b want busy rem6", obs());
    end
    tests++;
    repeat (26) begin
      idle();
      if (tif.expired && first < 0) first = cyc - s0;
      if (obs() !== mvec()) begin
        fails++; $display("FAIL base_cycle c%0d got %b want %b", cyc - s0, obs(), mvec());
      end
      tests++;
    end
    if (first !== 24) begin
      fails++; $display("FAIL base_latency got %0d want 24", first);
    end
    tests++;
  endtask

  task test_program();
    int s0, first;
    step(0, 0, 1, 2, 5);
    first = -1;
    step(1, 2, 0, 0, 0); s0 = cyc;
    repeat (22) begin
      idle();
      if (tif.expired && first < 0) first = cyc - s0;
      if (obs() !== mvec()) begin
        fails++; $display("FAIL prog_cycle c%0d got %b want %b", cyc - s0, obs(), mvec());
      end
      tests++;
    end
    if (first !== 20) begin
      fails++; $display("FAIL prog_yellow_latency got %0d want 20", first);
    end
    tests++;
    first = -1;
    step(1, 3, 0, 0, 0); s0 = cyc;
    repeat (6) begin
      idle();
      if (tif.expired && first < 0) first = cyc - s0;
    end
    if (first !== 4) begin
      fails++; $display("FAIL prog_addr3_latency got %0d want 4", first);
    end
    tests++;
  endtask

  task test_restart();
    int s0, first, nexp;
    first = -1; nexp = 0;
    step(1, 0, 0, 0, 0); s0 = cyc;
    repeat (8) idle();
    step(1, 1, 0, 0, 0);
    repeat (16) begin
      idle();
      if (tif.expired) begin nexp++; if (first < 0) first = cyc - s0; end
      if (obs() !== mvec()) begin
        fails++; $display("FAIL restart_cycle c%0d got %b want %b", cyc - s0, obs(), mvec());
      end
      tests++;
    end
    if (first !== 21 || nexp !== 1) begin
      fails++; $display("FAIL restart_expiry got at %0d count %0d want at 21 count 1", first, nexp);
    end
    tests++;
  endtask

  task test_abort();
    int s0, first;
    step(1, 1, 0, 0, 0);
    repeat (5) idle();
    step(0, 0, 1, 3, 9);
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL abort_outputs got %b want %b", obs(), 7'd0);
    end
    tests++;
    repeat (10) begin
      idle();
      if (tif.expired !== 1'b0) begin
        fails++; $display("FAIL abort_no_expired got %b want 0", tif.expired);
      end
      tests++;
    end
    first = -1;
    // start and program in the same cycle: programming wins, no count starts
    step(1, 1, 1, 3, 0);
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL prg_wins got %b want %b", obs(), 7'd0);
    end
    tests++;
    step(1, 1, 0, 0, 0); s0 = cyc;
    repeat (14) begin
      idle();
      if (tif.expired && first < 0) first = cyc - s0;
    end
    if (first !== 12) begin
      fails++; $display("FAIL abort_table_kept got %0d want 12", first);
    end
    tests++;
  endtask

  task test_zero();
    int s0, first;
    first = -1;
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0); s0 = cyc;
    if (tif.remaining !== 4'd1) begin
      fails++; $display("FAIL zero_remaining got %0d want 1", tif.remaining);
    end
    tests++;
    repeat (6) begin
      idle();
      if (tif.expired && first < 0) first = cyc - s0;
    end
    if (first !== 4) begin
      fails++; $display("FAIL zero_latency got %0d want 4", first);
    end
    tests++;
  endtask

  task test_back_to_back();
    int s0, s1, guard;
    step(1, 3, 0, 0, 0); s0 = cyc;
    guard = 0;
    while (!tif.expired && guard < 10) begin idle(); guard++; end
    if (cyc - s0 !== 4) begin
      fails++; $display("FAIL b2b_first got %0d want 4", cyc - s0);
    end
    tests++;
    step(1, 2, 0, 0, 0); s1 = cyc;
    if (obs() !== mvec()) begin
      fails++; $display("FAIL b2b_restart got %b want %b", obs(), mvec());
    end
    tests++;
    guard = 0;
    while (!tif.expired && guard < 30) begin idle(); guard++; end
    if (cyc - s1 !== 20) begin
      fails++; $display("FAIL b2b_second got %0d want 20", cyc - s1);
    end
    tests++;
  endtask

  task test_async_reset();
    int s0, first;
    step(1, 0, 0, 0, 0);
    repeat (7) idle();
    #3 sys_reset = 1'b0;
    #1;
    if (obs() !== 7'd0) begin
      fails++; $display("FAIL async_reset got %b want %b", obs(), 7'd0);
    end
    tests++;
    model_reset();
    @(negedge clk);
    sys_reset = 1'b1;
    first = -1;
    step(1, 0, 0, 0, 0); s0 = cyc;
    repeat (26) begin
      idle();
      if (tif.expired && first < 0) first = cyc - s0;
    end
    if (first !== 24) begin
      fails++; $display("FAIL async_table_default got %0d want 24", first);
    end
    tests++;
  endtask

  task test_random();
    bit st, pl;
    repeat (800) begin
      st = ($urandom_range(0, 7) == 0);
      pl = ($urandom_range(0, 29) == 0);
      step(st, $urandom_range(0, 3), pl, $urandom_range(0, 3), $urandom_range(0, 4));
      if (obs() !== mvec()) begin
        fails++; $display("FAIL random c%0d got %b want %b", cyc, obs(), mvec());
      end
      tests++;
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_program();
    test_restart();
    test_abort();
    test_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
